sram_burst_master: RTL and testbench
====================================

// Module: sram_burst_master
// PURPOSE
// - Initiator for the 17-bit x 16-bit single-port SRAM operand store. It converts burst commands into per-word SRAM accesses.
// - Write bursts take a valid/ready stream and write it to consecutive addresses.
// - Read bursts fetch consecutive addresses and return the words on a valid/ready stream through a 4-entry buffer.
// - Sits between the compute datapath / loader and the SRAM instance.
// PARAMETERS
// - A_WIDTH   17  SRAM address width
// - D_WIDTH   16  SRAM data width
// - LEN_WIDTH 8   burst length field; words per burst = Cmd_Len+1 (1..256)
// PORTS
// - Clk           in   1        single clock, all logic on posedge
// - Rst           in   1        synchronous, active-high reset
// - Cmd_Valid     in   1        command offered
// - Cmd_Ready     out  1        high only in IDLE
// - Cmd_Write     in   1        1=write burst, 0=read burst
// - Cmd_Addr      in   A_WIDTH  start address
// - Cmd_Len       in   LEN_WIDTH  word count minus one
// - Wr_Data       in   D_WIDTH  write stream data
// - Wr_Valid      in   1        write word offered
// - Wr_Ready      out  1        high only in WRITE state
// - Rd_Data       out  D_WIDTH  read stream data (buffer head)
// - Rd_Valid      out  1        buffer non-empty
// - Rd_Ready      in   1        consumer accepts
// - Done          out  1        one-cycle pulse at burst completion
// - Sram_Addr     out  A_WIDTH  to SRAM Addr (registered)
// - Sram_RW       out  1        to SRAM RW: 1=write, 0=read (registered)
// - Sram_En       out  1        to SRAM En (registered)
// - Sram_Wdata    out  D_WIDTH  to SRAM Data_In (registered)
// - Sram_Rdata    in   D_WIDTH  from SRAM Data_Out; valid exactly 1 cycle after an En=1,RW=0 cycle
// BEHAVIOUR
// - Reset: every output is 0 (Cmd_Ready is 0 during reset and 1 the cycle after). State=IDLE, buffer and counters cleared.
// - Reset mid-burst aborts the burst with no Done pulse. Remaining words are discarded.
// - States: IDLE -> (accept) WRITE | READ. WRITE -> FIN after the last write handshake. READ -> FIN when the last word is popped. FIN -> IDLE (Done=1 in FIN).
// - Accept: Cmd_Valid && Cmd_Ready at edge. Cur_Addr<=Cmd_Addr, Remain<=Cmd_Len+1 (9 bits). Commands are ignored outside IDLE.
// - WRITE: Wr_Ready=1. Each Wr_Valid&&Wr_Ready registers Sram_En=1, RW=1, Addr=Cur_Addr, Wdata=Wr_Data for the next cycle only. Then Cur_Addr++ and Remain--.
// - WRITE with no handshake: Sram_En=0 the next cycle. The SRAM write happens 1 cycle after the handshake.
// - READ issue rule: issue iff Issued<Len+1 && (buf_count + inflight) < 4. inflight counts issued words not yet in the buffer (0..2).
// - READ issue: registers Sram_En=1, RW=0, Addr=Cur_Addr for the next cycle, then Cur_Addr++.
// - READ capture: Sram_Rdata is pushed into the buffer on the cycle after each Sram_En read cycle. The buffer never overflows by construction.
// - READ pop: Rd_Valid && Rd_Ready pops the head.
// - READ latency: command accepted in cycle 0 gives first Rd_Valid in cycle 4. Sustained throughput is 1 word/cycle with Rd_Ready=1.
// - Rd_Ready=0: issue stalls once buf+inflight=4. No word is lost or duplicated.
// - Address wrap: Cur_Addr increments modulo 2^A_WIDTH (0x1FFFF -> 0x00000) with no error.
// - Sram_RW is held 0 whenever Sram_En=0. Sram_Wdata is 0 when not writing.
// - Done: exactly 1 cycle in FIN, then Cmd_Ready=1 the next cycle. Minimum burst of 1 word is supported.
// CONFIGURATION
// - SRAM_MASTER_STATS_EN defined: adds output Word_Count [31:0].
//   - Counts every SRAM access issued (read or write) and saturates at 0xFFFFFFFF.
//   - Cleared only by Rst.
// - SRAM_MASTER_STATS_EN undefined: port and counter are absent. All other behaviour is identical.
// TESTING
// - Reset: hold Rst 3 cycles mid-read burst -> all outputs 0 during Rst, Cmd_Ready=1 next cycle, no Done, Rd_Valid=0.
// - Write burst: Addr=0x00010, Len=3, Wr_Valid=1 with data A0..A3.
//   -> Sram_En=1, RW=1 on 4 consecutive cycles at 0x10..0x13 with A0..A3, then Done pulse once.
// - Read back: Addr=0x00010, Len=3, Rd_Ready=1 -> Rd_Valid first in cycle 4 after accept, data A0..A3 on 4 consecutive cycles, Done once.
// - Backpressure: read Len=15 with Rd_Ready toggling 1 cycle high / 3 low.
//   -> 16 words in order, buf+inflight never exceeds 4, Sram_En never reads past address start+15.
// - Wrap: write Len=1 at Addr=0x1FFFF -> writes land at 0x1FFFF then 0x00000. Read back returns the same two words.
// - Stats (SRAM_MASTER_STATS_EN): after the write and read scenarios above -> Word_Count=8.
//   - Then 256-word read (Len=255) -> Word_Count=264.

Source files
------------

// File: rtl/sram_burst_master.sv
// sram_burst_master: burst-command initiator for a single-port SRAM (1-cycle read latency).
// Optional build macro SRAM_MASTER_STATS_EN adds the Word_Count access counter output.
`default_nettype none

module sram_burst_master #(
  parameter int A_WIDTH   = 17,
  parameter int D_WIDTH   = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic                 Cmd_Write,
  input  logic [A_WIDTH-1:0]   Cmd_Addr,
  input  logic [LEN_WIDTH-1:0] Cmd_Len,
  input  logic [D_WIDTH-1:0]   Wr_Data,
  input  logic                 Wr_Valid,
  output logic                 Wr_Ready,
  output logic [D_WIDTH-1:0]   Rd_Data,
  output logic                 Rd_Valid,
  input  logic                 Rd_Ready,
  output logic                 Done,
  output logic [A_WIDTH-1:0]   Sram_Addr,
  output logic                 Sram_RW,
  output logic                 Sram_En,
  output logic [D_WIDTH-1:0]   Sram_Wdata,
  input  logic [D_WIDTH-1:0]   Sram_Rdata
`ifdef SRAM_MASTER_STATS_EN
  ,
  output logic [31:0]          Word_Count
`endif
);

  localparam int CNT_W = LEN_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [A_WIDTH-1:0] cur_addr;
  logic [CNT_W-1:0]   remain;      // words still to hand over (write handshakes or read pops)
  logic [CNT_W-1:0]   issue_left;  // read accesses not yet issued
  logic [1:0]         inflight;
  logic               capture;
  logic [D_WIDTH-1:0] buf_mem [0:3];
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         buf_count;

  logic accept, wr_hs, rd_pop, rd_issue, last_word;
  logic [3:0] occupancy;

  assign accept    = Cmd_Valid && Cmd_Ready;
  assign wr_hs     = Wr_Valid && Wr_Ready;
  assign rd_pop    = Rd_Valid && Rd_Ready;
  assign last_word = (remain == CNT_W'(1));
  assign occupancy = 4'(buf_count) + 4'(inflight);
  // Words already issued count against the buffer, so a push can never find it full.
  assign rd_issue  = (state == ST_READ) && (issue_left != '0) && (occupancy < 4'd4);

  always_ff @(posedge Clk) begin : state_reg
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)              state_nxt = Cmd_Write ? ST_WRITE : ST_READ;
      ST_WRITE: if (wr_hs && last_word)  state_nxt = ST_FIN;
      ST_READ:  if (rd_pop && last_word) state_nxt = ST_FIN;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : state_outputs
    Cmd_Ready = (state == ST_IDLE) && !Rst;
    Wr_Ready  = (state == ST_WRITE);
    Done      = (state == ST_FIN);
  end

  always_ff @(posedge Clk) begin : burst_counters
    if (Rst) begin
      cur_addr   <= '0;
      remain     <= '0;
      issue_left <= '0;
    end else begin
      if (accept) begin
        cur_addr   <= Cmd_Addr;
        remain     <= {1'b0, Cmd_Len} + CNT_W'(1);
        issue_left <= Cmd_Write ? '0 : ({1'b0, Cmd_Len} + CNT_W'(1));
      end else begin
        if (wr_hs || rd_issue) cur_addr   <= cur_addr + A_WIDTH'(1);
        if (wr_hs || rd_pop)   remain     <= remain - CNT_W'(1);
        if (rd_issue)          issue_left <= issue_left - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin : sram_drive
    if (Rst) begin
      Sram_En    <= 1'b0;
      Sram_RW    <= 1'b0;
      Sram_Addr  <= '0;
      Sram_Wdata <= '0;
    end else begin
      Sram_En    <= 1'b0;
      Sram_RW    <= 1'b0;
      Sram_Wdata <= '0;
      if (wr_hs) begin
        Sram_En    <= 1'b1;
        Sram_RW    <= 1'b1;
        Sram_Addr  <= cur_addr;
        Sram_Wdata <= Wr_Data;
      end else if (rd_issue) begin
        Sram_En    <= 1'b1;
        Sram_Addr  <= cur_addr;
      end
    end
  end

  always_ff @(posedge Clk) begin : read_tracking
    if (Rst) begin
      capture   <= 1'b0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      capture   <= Sram_En && !Sram_RW;
      inflight  <= inflight + 2'(rd_issue) - 2'(capture);
      if (capture) wr_ptr <= wr_ptr + 2'd1;
      if (rd_pop)  rd_ptr <= rd_ptr + 2'd1;
      buf_count <= buf_count + 3'(capture) - 3'(rd_pop);
    end
  end

  always_ff @(posedge Clk) begin : buffer_store
    if (capture) buf_mem[wr_ptr] <= Sram_Rdata;
  end

  assign Rd_Valid = (buf_count != '0);
  assign Rd_Data  = Rd_Valid ? buf_mem[rd_ptr] : '0;

`ifdef SRAM_MASTER_STATS_EN
  always_ff @(posedge Clk) begin : access_stats
    if (Rst)                                        Word_Count <= '0;
    else if ((wr_hs || rd_issue) && !(&Word_Count)) Word_Count <= Word_Count + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_master.sv
// tb_sram_burst_master: directed self-checking bench for sram_burst_master with a behavioural SRAM.
// Build with SRAM_MASTER_STATS_EN defined to also check Word_Count.
`default_nettype none

module tb_sram_burst_master;

  logic        Clk, Rst;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Write;
  logic [16:0] Cmd_Addr;
  logic [7:0]  Cmd_Len;
  logic [15:0] Wr_Data;
  logic        Wr_Valid, Wr_Ready;
  logic [15:0] Rd_Data;
  logic        Rd_Valid, Rd_Ready, Done;
  logic [16:0] Sram_Addr;
  logic        Sram_RW, Sram_En;
  logic [15:0] Sram_Wdata, Sram_Rdata;
`ifdef SRAM_MASTER_STATS_EN
  logic [31:0] Word_Count;
`endif

  sram_burst_master dut (
    .Clk(Clk), .Rst(Rst),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wr_Data(Wr_Data), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
    .Rd_Data(Rd_Data), .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Done(Done),
    .Sram_Addr(Sram_Addr), .Sram_RW(Sram_RW), .Sram_En(Sram_En),
    .Sram_Wdata(Sram_Wdata), .Sram_Rdata(Sram_Rdata)
`ifdef SRAM_MASTER_STATS_EN
    , .Word_Count(Word_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input logic [16:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Behavioural SRAM: unwritten locations read back as pat(addr).
  logic [15:0] mem [int];
  initial Sram_Rdata = '0;
  always @(posedge Clk) begin
    if (Sram_En && Sram_RW) mem[int'(Sram_Addr)] = Sram_Wdata;
    if (Sram_En && !Sram_RW)
      Sram_Rdata <= mem.exists(int'(Sram_Addr)) ? mem[int'(Sram_Addr)] : pat(Sram_Addr);
  end

  // Monitor: owns all observation state; cleared on request from the stimulus.
  int          clr_gen = 0, seen_gen = 0;
  logic [16:0] acc_addr[$];
  logic        acc_rw[$];
  logic [15:0] acc_data[$];
  int          acc_cyc[$];
  logic [15:0] rd_q[$];
  int          rd_cyc[$];
  int n_rd_iss = 0, n_pop = 0, max_out = 0, done_cnt = 0, done_cyc = 0, cmd_cyc = 0, bad_idle = 0;

  always @(negedge Clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      acc_addr.delete(); acc_rw.delete(); acc_data.delete(); acc_cyc.delete();
      rd_q.delete(); rd_cyc.delete();
      n_rd_iss = 0; n_pop = 0; max_out = 0; done_cnt = 0;
    end
    if (Sram_En) begin
      acc_addr.push_back(Sram_Addr); acc_rw.push_back(Sram_RW);
      acc_data.push_back(Sram_Wdata); acc_cyc.push_back(cyc);
      if (!Sram_RW) n_rd_iss++;
    end
    if ((!Sram_En && (Sram_RW || Sram_Wdata != 0)) || (Sram_En && !Sram_RW && Sram_Wdata != 0))
      bad_idle++;
    if (n_rd_iss - n_pop > max_out) max_out = n_rd_iss - n_pop;
    if (Rd_Valid && Rd_Ready) begin
      rd_q.push_back(Rd_Data); rd_cyc.push_back(cyc); n_pop++;
    end
    if (Cmd_Valid && Cmd_Ready) cmd_cyc = cyc;
    if (Done) begin done_cnt++; done_cyc = cyc; end
  end

  int n_cmp = 0, n_fail = 0, idle_cyc = 0;
  logic [15:0] wq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [16:0] a, input logic [7:0] l);
    int t = 0;
    Cmd_Write = wr; Cmd_Addr = a; Cmd_Len = l; Cmd_Valid = 1'b1;
    @(negedge Clk);
    while (!Cmd_Ready && t < 50) begin t++; @(negedge Clk); end
    check("cmd_accept_timeout", 64'(t < 50), 64'd1);
    @(posedge Clk); #1;
    Cmd_Valid = 1'b0;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [7:0] l);
    int t;
    send_cmd(1'b1, a, l);
    foreach (wq[i]) begin
      Wr_Data = wq[i]; Wr_Valid = 1'b1; t = 0;
      @(negedge Clk);
      while (!Wr_Ready && t < 50) begin t++; @(negedge Clk); end
      @(posedge Clk); #1;
    end
    Wr_Valid = 1'b0; Wr_Data = '0;
  endtask

  task automatic wait_idle(input bit bp);
    int t = 0, k = 0;
    @(negedge Clk);
    while (!Cmd_Ready && t < 1000) begin
      @(posedge Clk); #1;
      if (bp) begin k++; Rd_Ready = (k % 4 == 0); end
      t++;
      @(negedge Clk);
    end
    idle_cyc = cyc;
    check("idle_timeout", 64'(t < 1000), 64'd1);
    @(posedge Clk); #1;
  endtask

  task automatic verify_writes(input string nm, input logic [16:0] base);
    check({nm, "_count"}, 64'(acc_addr.size()), 64'(wq.size()));
    for (int i = 0; i < wq.size() && i < acc_addr.size(); i++) begin
      check($sformatf("%s_addr[%0d]", nm, i), 64'(acc_addr[i]), 64'(17'(base + 17'(i))));
      check($sformatf("%s_rw[%0d]", nm, i), 64'(acc_rw[i]), 64'd1);
      check($sformatf("%s_data[%0d]", nm, i), 64'(acc_data[i]), 64'(wq[i]));
    end
    if (acc_cyc.size() == wq.size())
      check({nm, "_back_to_back"}, 64'(acc_cyc[wq.size()-1] - acc_cyc[0]), 64'(wq.size() - 1));
    check({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({nm, "_ready_after_done"}, 64'(idle_cyc - done_cyc), 64'd1);
  endtask

  task automatic verify_reads(input string nm, input int n);
    check({nm, "_count"}, 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++)
      check($sformatf("%s_data[%0d]", nm, i), 64'(rd_q[i]), 64'(wq[i]));
    check({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {9'd0, Cmd_Ready, Wr_Ready, Rd_Data, Rd_Valid, Done, Sram_Addr, Sram_RW, Sram_En, Sram_Wdata}, 64'd0);
`ifdef SRAM_MASTER_STATS_EN
    check({nm, "_word_count"}, 64'(Word_Count), 64'd0);
`endif
  endtask

  initial begin
    Rst = 1'b1; Cmd_Valid = 1'b0; Cmd_Write = 1'b0; Cmd_Addr = '0; Cmd_Len = '0;
    Wr_Data = '0; Wr_Valid = 1'b0; Rd_Ready = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("init_rst_outputs");
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    check("init_cmd_ready", 64'(Cmd_Ready), 64'd1);
    @(posedge Clk); #1;

    // Write burst of 4 words at 0x10.
    wq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    clr_gen++;
    do_write(17'h00010, 8'd3);
    wait_idle(0);
    verify_writes("wr4", 17'h00010);

    // Read the same 4 words back with the consumer always ready.
    Rd_Ready = 1'b1; clr_gen++;
    send_cmd(1'b0, 17'h00010, 8'd3);
    wait_idle(0);
    verify_reads("rd4", 4);
    if (rd_cyc.size() == 4) begin
      check("rd4_first_latency", 64'(rd_cyc[0] - cmd_cyc), 64'd4);
      check("rd4_back_to_back", 64'(rd_cyc[3] - rd_cyc[0]), 64'd3);
    end

`ifdef SRAM_MASTER_STATS_EN
    check("stats_after_8", 64'(Word_Count), 64'd8);
    clr_gen++;
    send_cmd(1'b0, 17'h00400, 8'd255);
    wait_idle(0);
    check("rd256_count", 64'(rd_q.size()), 64'd256);
    check("stats_after_264", 64'(Word_Count), 64'd264);
`endif

    // Single-word write burst.
    wq = '{16'h1234};
    clr_gen++;
    do_write(17'h00020, 8'd0);
    wait_idle(0);
    verify_writes("wr1", 17'h00020);

    // 16-word read with Rd_Ready high 1 cycle in 4.
    Rd_Ready = 1'b0; clr_gen++;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(pat(17'h00100 + 17'(i)));
    send_cmd(1'b0, 17'h00100, 8'd15);
    wait_idle(1);
    verify_reads("bp", 16);
    check("bp_max_outstanding", 64'(max_out), 64'd4);
    check("bp_sram_reads", 64'(n_rd_iss), 64'd16);
    if (acc_addr.size() > 0) check("bp_last_read_addr", 64'(acc_addr[acc_addr.size()-1]), 64'h10F);

    // Address wrap 0x1FFFF -> 0x00000, then read back.
    Rd_Ready = 1'b1;
    wq = '{16'hBEEF, 16'hCAFE};
    clr_gen++;
    do_write(17'h1FFFF, 8'd1);
    wait_idle(0);
    verify_writes("wrap_wr", 17'h1FFFF);
    clr_gen++;
    send_cmd(1'b0, 17'h1FFFF, 8'd1);
    wait_idle(0);
    verify_reads("wrap_rd", 2);
    check("sram_idle_encoding", 64'(bad_idle), 64'd0);

    // Reset in the middle of a stalled read burst.
    Rd_Ready = 1'b0; clr_gen++;
    send_cmd(1'b0, 17'h00200, 8'd15);
    repeat (6) @(posedge Clk);
    #1 Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_all_zero($sformatf("midrst_outputs[%0d]", i));
    end
    @(posedge Clk); #1 Rst = 1'b0; Rd_Ready = 1'b1; clr_gen++;
    @(negedge Clk);
    check("midrst_cmd_ready", 64'(Cmd_Ready), 64'd1);
    check("midrst_rd_valid", 64'(Rd_Valid), 64'd0);
    repeat (5) @(negedge Clk);
    check("midrst_no_pops", 64'(rd_q.size()), 64'd0);
    check("midrst_no_access", 64'(acc_addr.size()), 64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
